param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file_pkg.sv | 14 +
 rtl/param_reg_file_if.sv | 32 +++
 rtl/param_reg_file_reg_cell.sv | 62 ++++++
 rtl/param_reg_file.sv | 73 +++++++
 tb/tb_param_reg_file.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/param_reg_file_pkg.sv
// Shared types for the parameterised register file: function-select encodings.
// Imported by the interface, the register cell and the top level.
package param_reg_file_pkg;

    typedef enum logic [1:0] {
        FUN_CLR  = 2'b00,
        FUN_LOAD = 2'b01,
        FUN_DEC  = 2'b10,
        FUN_INC  = 2'b11
    } fun_e;

    localparam int FUN_W = 2;

endpackage

// File: rtl/param_reg_file_if.sv
// Command/read bus of the register file; master drives commands, slave returns read data.
// No handshake: one command per cycle, outputs valid one cycle after the edge.
interface param_reg_file_if
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
);
    localparam int SELW = $clog2(NREG);

    logic             en;
    logic [FUN_W-1:0] fun_sel;
    logic [NREG-1:0]  reg_sel;
    logic [WIDTH-1:0] i_data;
    logic [SELW-1:0]  o1_sel;
    logic [SELW-1:0]  o2_sel;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic             o1_zero;
    logic             ovf;

    modport master (
        output en, fun_sel, reg_sel, i_data, o1_sel, o2_sel,
        input  o1, o2, o1_zero, ovf
    );

    modport slave (
        input  en, fun_sel, reg_sel, i_data, o1_sel, o2_sel,
        output o1, o2, o1_zero, ovf
    );

endinterface

// File: rtl/param_reg_file_reg_cell.sv
// One WIDTH-bit register with clear/load/inc/dec, wrap or saturate; next value exposed for read bypass.
// Latency 1 cycle; no backpressure, an update is accepted on every enabled edge.
module reg_cell
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd,
    input  fun_e             i_fun,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_ovf_event
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_nxt;
    logic             w_ovf;

    always_comb begin
        w_nxt = r_q;
        w_ovf = 1'b0;
        if (i_upd) begin
            case (i_fun)
                FUN_CLR:  w_nxt = '0;
                FUN_LOAD: w_nxt = i_data;
                FUN_DEC: begin
                    if (r_q == '0) begin
                        w_ovf = 1'b1;
                        w_nxt = (SAT != 0) ? r_q : '1;
                    end else begin
                        w_nxt = r_q - ONE;
                    end
                end
                FUN_INC: begin
                    // Overflow is flagged at the boundary even when saturating
                    if (r_q == '1) begin
                        w_ovf = 1'b1;
                        w_nxt = (SAT != 0) ? r_q : '0;
                    end else begin
                        w_nxt = r_q + ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_nxt;
        end
    end

    assign o_nxt       = w_nxt;
    assign o_ovf_event = w_ovf;

endmodule

// File: rtl/param_reg_file.sv
// NREG-entry register file with multi-select update and two registered write-through read ports.
// Latency 1 cycle; no backpressure, a command is consumed on every clock edge.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int SAT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    param_reg_file_if.slave bus
);
    localparam int SELW = $clog2(NREG);

    logic [WIDTH-1:0] w_nxt [NREG];
    logic [NREG-1:0]  w_ovf_evt;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    fun_e             w_fun;

    logic [WIDTH-1:0] r_o1;
    logic [WIDTH-1:0] r_o2;
    logic             r_o1_zero;
    logic             r_ovf;

    assign w_fun = fun_e'(bus.fun_sel);

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        reg_cell #(
            .WIDTH (WIDTH),
            .SAT   (SAT)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .i_upd       (bus.en & bus.reg_sel[k]),
            .i_fun       (w_fun),
            .i_data      (bus.i_data),
            .o_nxt       (w_nxt[k]),
            .o_ovf_event (w_ovf_evt[k])
        );
    end

    // Muxing the cells' next values gives write-through; unmatched indices read 0
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int k = 0; k < NREG; k++) begin
            if (bus.o1_sel == SELW'(k)) w_rd1 = w_nxt[k];
            if (bus.o2_sel == SELW'(k)) w_rd2 = w_nxt[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o1      <= '0;
            r_o2      <= '0;
            r_o1_zero <= 1'b1;
            r_ovf     <= 1'b0;
        end else begin
            r_o1      <= w_rd1;
            r_o2      <= w_rd2;
            r_o1_zero <= (w_rd1 == '0);
            r_ovf     <= |w_ovf_evt;
        end
    end

    assign bus.o1      = r_o1;
    assign bus.o2      = r_o2;
    assign bus.o1_zero = r_o1_zero;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: wrap (SAT=0) and saturate (SAT=1) instances share one stimulus stream.
// A reference model per instance pushes expected read data to a scoreboard queue on every command.
module tb_param_reg_file;

    typedef struct packed {
        logic [7:0] o1;
        logic [7:0] o2;
        logic       z;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] fun_sel;
    logic [7:0] reg_sel;
    logic [7:0] i_data;
    logic [2:0] o1_sel;
    logic [2:0] o2_sel;

    logic [7:0] mdl [2][8];
    exp_t       sbq0[$];
    exp_t       sbq1[$];
    int         n_checks = 0;
    int         n_fails  = 0;

    param_reg_file_if #(.WIDTH(8), .NREG(8)) bus0 ();
    param_reg_file_if #(.WIDTH(8), .NREG(8)) bus1 ();

    assign bus0.en = en;  assign bus0.fun_sel = fun_sel; assign bus0.reg_sel = reg_sel;
    assign bus0.i_data = i_data; assign bus0.o1_sel = o1_sel; assign bus0.o2_sel = o2_sel;
    assign bus1.en = en;  assign bus1.fun_sel = fun_sel; assign bus1.reg_sel = reg_sel;
    assign bus1.i_data = i_data; assign bus1.o1_sel = o1_sel; assign bus1.o2_sel = o2_sel;

    param_reg_file #(.WIDTH(8), .NREG(8), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    param_reg_file #(.WIDTH(8), .NREG(8), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cmp_outs(input string tag, input exp_t act, input exp_t exp);
        check_val({tag, ".o1"},      32'(act.o1),  32'(exp.o1));
        check_val({tag, ".o2"},      32'(act.o2),  32'(exp.o2));
        check_val({tag, ".o1_zero"}, 32'(act.z),   32'(exp.z));
        check_val({tag, ".ovf"},     32'(act.ovf), 32'(exp.ovf));
    endtask

    function automatic exp_t act0();
        return '{bus0.o1, bus0.o2, bus0.o1_zero, bus0.ovf};
    endfunction

    function automatic exp_t act1();
        return '{bus1.o1, bus1.o2, bus1.o1_zero, bus1.ovf};
    endfunction

    // s = 0 models the wrapping instance, s = 1 the saturating one
    task automatic model_step(input int s, output exp_t x);
        logic ov;
        ov = 1'b0;
        if (en) begin
            for (int k = 0; k < 8; k++) begin
                if (reg_sel[k]) begin
                    case (fun_sel)
                        2'b00: mdl[s][k] = 8'h00;
                        2'b01: mdl[s][k] = i_data;
                        2'b10: begin
                            if (mdl[s][k] == 8'h00) begin
                                ov = 1'b1;
                                if (s == 0) mdl[s][k] = 8'hFF;
                            end else mdl[s][k] = mdl[s][k] - 8'd1;
                        end
                        default: begin
                            if (mdl[s][k] == 8'hFF) begin
                                ov = 1'b1;
                                if (s == 0) mdl[s][k] = 8'h00;
                            end else mdl[s][k] = mdl[s][k] + 8'd1;
                        end
                    endcase
                end
            end
        end
        x.o1  = mdl[s][o1_sel];
        x.o2  = mdl[s][o2_sel];
        x.z   = (mdl[s][o1_sel] == 8'h00);
        x.ovf = ov;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 8; k++) mdl[s][k] = 8'h00;
    endtask

    task automatic step(input string tag, input logic e, input logic [1:0] f,
                        input logic [7:0] sel, input logic [7:0] d,
                        input int s1, input int s2);
        exp_t x0, x1;
        en      = e;
        fun_sel = f;
        reg_sel = sel;
        i_data  = d;
        o1_sel  = 3'(s1);
        o2_sel  = 3'(s2);
        model_step(0, x0);
        model_step(1, x1);
        sbq0.push_back(x0);
        sbq1.push_back(x1);
        @(posedge clk);
        #1;
        if (sbq0.size() == 0 || sbq1.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            cmp_outs({tag, "/wrap"}, act0(), sbq0.pop_front());
            cmp_outs({tag, "/sat"},  act1(), sbq1.pop_front());
        end
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < 8; k++) step(tag, 1'b0, 2'b11, 8'hFF, 8'h00, k, 7 - k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rst_exp;
        rst_exp = '{8'h00, 8'h00, 1'b1, 1'b0};
        rst = 1'b1; en = 1'b0; fun_sel = 2'b00; reg_sel = 8'h00;
        i_data = 8'h00; o1_sel = 3'd0; o2_sel = 3'd0;
        model_reset();
        #2;
        cmp_outs("reset/wrap", act0(), rst_exp);
        cmp_outs("reset/sat",  act1(), rst_exp);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // load-and-read
        step("load3", 1'b1, 2'b01, 8'h08, 8'h5A, 3, 0);

        // multi-select load then two increments
        step("mload", 1'b1, 2'b01, 8'h81, 8'h11, 0, 7);
        step("minc1", 1'b1, 2'b11, 8'h81, 8'h00, 0, 7);
        step("minc2", 1'b1, 2'b11, 8'h81, 8'h00, 0, 7);
        sweep("msweep");

        // wrap / overflow pulse on reg 2
        step("ld_ff2", 1'b1, 2'b01, 8'h04, 8'hFF, 2, 3);
        step("inc2",   1'b1, 2'b11, 8'h04, 8'h00, 2, 3);
        step("idle2",  1'b0, 2'b11, 8'h04, 8'h00, 2, 3);
        step("dec2",   1'b1, 2'b10, 8'h04, 8'h00, 2, 3);

        // saturate at zero / all-ones on reg 4
        step("clr4",   1'b1, 2'b00, 8'h10, 8'h00, 4, 2);
        for (int i = 0; i < 3; i++) step("dec4", 1'b1, 2'b10, 8'h10, 8'h00, 4, 2);
        step("ld_ff4", 1'b1, 2'b01, 8'h10, 8'hFF, 4, 2);
        step("inc4",   1'b1, 2'b11, 8'h10, 8'h00, 4, 2);

        // write-through on both ports, hold paths
        step("byp5",    1'b1, 2'b01, 8'h20, 8'h3C, 5, 5);
        step("hold_en", 1'b0, 2'b11, 8'hFF, 8'h00, 5, 4);
        step("nosel",   1'b1, 2'b11, 8'h00, 8'h00, 4, 5);
        sweep("hsweep");

        // async reset in the middle of an increment that would overflow
        step("ld_ff6", 1'b1, 2'b01, 8'h40, 8'hFF, 5, 6);
        step("inc6",   1'b1, 2'b11, 8'h40, 8'h00, 5, 6);
        en = 1'b1; fun_sel = 2'b11; reg_sel = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        cmp_outs("arst/wrap", act0(), rst_exp);
        cmp_outs("arst/sat",  act1(), rst_exp);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_outs("arst_hold/wrap", act0(), rst_exp);
        cmp_outs("arst_hold/sat",  act1(), rst_exp);
        @(negedge clk);
        rst = 1'b0;
        sweep("rsweep");
        step("post_ld", 1'b1, 2'b01, 8'h02, 8'hA5, 1, 0);

        check_val("sb_drained", 32'(sbq0.size() + sbq1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
